// File: rtl/ins_prefetch_queue.sv
// rtl/ins_prefetch_queue.sv - instruction prefetch queue between a 1-cycle-latency ROM and the core
module ins_prefetch_queue #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12,
  parameter int DEPTH    = 4,
  parameter int PTRW     = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                rom_en,
  output logic [ADDRSIZE-1:0] rom_addr,
  input  logic [WIDTH-1:0]    rom_data,
  output logic                ins_valid,
  output logic [WIDTH-1:0]    ins_data,
  output logic [ADDRSIZE-1:0] ins_pc,
  input  logic                ins_ready,
  input  logic                redirect,
  input  logic [ADDRSIZE-1:0] redirect_pc,
  input  logic                halt,
  output logic [PTRW:0]       count
);

  localparam int EW = WIDTH + ADDRSIZE;

  logic [ADDRSIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRSIZE-1:0] inflight_pc_q, inflight_pc_d;
  logic                inflight_q, inflight_d;
  logic [PTRW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTRW:0]       count_q, count_d;
  logic [EW-1:0]       mem_q [DEPTH];
  logic [EW-1:0]       mem_d [DEPTH];

  logic [PTRW+1:0]     occupancy;
  logic                issue;
  logic                push;
  logic                pop;

  // Issue decision, head presentation and handshake strobes; everything is forced quiet in reset
  always_comb begin
    occupancy = {1'b0, count_q} + {{(PTRW+1){1'b0}}, inflight_q};
    // Pre-pop occupancy keeps the space test conservative so a returning word always has a slot
    issue     = rst & ~halt & (redirect | (occupancy < (PTRW+2)'(DEPTH)));
    rom_en    = issue;
    rom_addr  = '0;
    if (rst) begin
      rom_addr = redirect ? redirect_pc : fetch_pc_q;
    end
    ins_valid = rst & (count_q != '0) & ~redirect;
    ins_data  = '0;
    ins_pc    = '0;
    if (rst) begin
      {ins_data, ins_pc} = mem_q[rd_ptr_q];
    end
    count = count_q;
    push  = inflight_q & ~redirect;
    pop   = ins_valid & ins_ready;
  end

  // Next-state for fetch pointer, in-flight tracking and FIFO bookkeeping; redirect wins over all
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    mem_d         = mem_q;

    if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = rom_addr;
      fetch_pc_d    = rom_addr + ADDRSIZE'(1);
    end else if (redirect) begin
      // Halted redirect: remember the target so releasing halt fetches it first
      fetch_pc_d = redirect_pc;
    end

    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {rom_data, inflight_pc_q};
        wr_ptr_d        = wr_ptr_q + PTRW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTRW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PTRW+1)'(1);
        2'b01:   count_d = count_q - (PTRW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register; asynchronous reset also discards any word still coming back from the ROM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= '0;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mem_q         <= mem_d;
    end
  end

endmodule

// File: tb/tb_ins_prefetch_queue.sv
// tb/tb_ins_prefetch_queue.sv - directed self-checking bench for ins_prefetch_queue
module tb_ins_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic        ins_valid;
  logic [31:0] ins_data;
  logic [11:0] ins_pc;
  logic        ins_ready;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic        halt;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic        inflight_m;
  logic        have_last = 1'b0;
  logic [11:0] last_pc = '0;

  ins_prefetch_queue #(.WIDTH(32), .ADDRSIZE(12), .DEPTH(4), .PTRW(2)) dut (
    .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc), .ins_ready(ins_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [11:0] a);
    return {20'b0, a} * 32'h11;
  endfunction

  // Synchronous ROM with one cycle of read latency
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_fn(rom_addr);
  end

  // Bench-side copy of the in-flight flag, used only for the occupancy invariant
  always @(posedge clk or negedge rst) begin
    if (!rst) inflight_m <= 1'b0;
    else      inflight_m <= rom_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  // Invariants plus data/sequence checking of every delivered word
  always @(negedge clk) begin
    if (!rst || redirect) have_last = 1'b0;
    if (rst) begin
      check("inv_count", {31'b0, count <= 3'd4}, 32'd1);
      check("inv_occ", {31'b0, ({1'b0, count} + {3'b0, inflight_m}) <= 4'd4}, 32'd1);
      if (ins_valid && ins_ready) begin
        check("mon_data", ins_data, rom_fn(ins_pc));
        if (have_last) check("mon_seq", {20'b0, ins_pc}, {20'b0, last_pc + 12'd1});
        last_pc   = ins_pc;
        have_last = 1'b1;
      end
    end
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; ins_ready = 1'b0;
    #1 rst = 1'b0;
    redirect = 1'b1; redirect_pc = 12'h123;
    // Reset state, with redirect asserted to show outputs are forced
    mid;
    check("rst_rom_en", {31'b0, rom_en}, 32'd0);
    check("rst_rom_addr", {20'b0, rom_addr}, 32'd0);
    check("rst_valid", {31'b0, ins_valid}, 32'd0);
    check("rst_count", {29'b0, count}, 32'd0);
    check("rst_ins_pc", {20'b0, ins_pc}, 32'd0);
    check("rst_ins_data", ins_data, 32'd0);
    nxt;
    redirect = 1'b0; ins_ready = 1'b1;
    nxt;
    rst = 1'b1;

    // Cold start: issue 0 in cycle 0, first valid in cycle 2
    mid;
    check("cold_c0_en", {31'b0, rom_en}, 32'd1);
    check("cold_c0_addr", {20'b0, rom_addr}, 32'd0);
    check("cold_c0_valid", {31'b0, ins_valid}, 32'd0);
    nxt; mid;
    check("cold_c1_valid", {31'b0, ins_valid}, 32'd0);
    check("cold_c1_addr", {20'b0, rom_addr}, 32'd1);
    nxt; mid;
    check("cold_c2_valid", {31'b0, ins_valid}, 32'd1);
    check("cold_c2_pc", {20'b0, ins_pc}, 32'd0);
    check("cold_c2_data", ins_data, 32'h0);
    nxt; mid;
    check("cold_c3_pc", {20'b0, ins_pc}, 32'd1);
    check("cold_c3_data", ins_data, 32'h11);
    nxt; mid;
    check("cold_c4_pc", {20'b0, ins_pc}, 32'd2);
    check("cold_c4_data", ins_data, 32'h22);
    check("cold_c4_count", {29'b0, count}, 32'd1);
    nxt;

    // Backpressure from reset: count saturates at 4, then drains without gap
    rst = 1'b0; ins_ready = 1'b0;
    nxt; nxt;
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      mid;
      if (c == 4) begin
        check("stall_c4_count", {29'b0, count}, 32'd3);
        check("stall_c4_en", {31'b0, rom_en}, 32'd0);
      end
      if (c == 9) begin
        check("stall_count", {29'b0, count}, 32'd4);
        check("stall_en", {31'b0, rom_en}, 32'd0);
        check("stall_valid", {31'b0, ins_valid}, 32'd1);
        check("stall_pc", {20'b0, ins_pc}, 32'd0);
      end
      nxt;
    end
    ins_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mid;
      check("drain_valid", {31'b0, ins_valid}, 32'd1);
      check("drain_pc", {20'b0, ins_pc}, i);
      if (i == 0) check("drain_c0_en", {31'b0, rom_en}, 32'd0);
      if (i == 1) begin
        check("drain_c1_en", {31'b0, rom_en}, 32'd1);
        check("drain_c1_addr", {20'b0, rom_addr}, 32'd4);
      end
      nxt;
    end

    // Redirect to 0x200 with count 3 and a word in flight
    rst = 1'b0; ins_ready = 1'b0;
    nxt; nxt;
    rst = 1'b1;
    nxt; nxt; nxt; nxt;
    redirect = 1'b1; redirect_pc = 12'h200;
    mid;
    check("redir_pre_count", {29'b0, count}, 32'd3);
    check("redir_valid", {31'b0, ins_valid}, 32'd0);
    check("redir_en", {31'b0, rom_en}, 32'd1);
    check("redir_addr", {20'b0, rom_addr}, 32'h200);
    nxt;
    redirect = 1'b0; ins_ready = 1'b1;
    mid;
    check("redir_n1_count", {29'b0, count}, 32'd0);
    check("redir_n1_valid", {31'b0, ins_valid}, 32'd0);
    check("redir_n1_addr", {20'b0, rom_addr}, 32'h201);
    nxt; mid;
    check("redir_n2_valid", {31'b0, ins_valid}, 32'd1);
    check("redir_n2_pc", {20'b0, ins_pc}, 32'h200);
    check("redir_n2_data", ins_data, 32'h2200);
    nxt; mid;
    check("redir_n3_pc", {20'b0, ins_pc}, 32'h201);
    check("redir_n3_data", ins_data, 32'h2211);
    nxt;

    // Address wrap 0xFFE -> 0x001
    redirect = 1'b1; redirect_pc = 12'hFFE;
    mid;
    check("wrap_redir_valid", {31'b0, ins_valid}, 32'd0);
    nxt;
    redirect = 1'b0;
    nxt; mid;
    check("wrap_pc0", {20'b0, ins_pc}, 32'hFFE);
    check("wrap_data0", ins_data, 32'h10FDE);
    nxt; mid;
    check("wrap_pc1", {20'b0, ins_pc}, 32'hFFF);
    check("wrap_data1", ins_data, 32'h10FEF);
    nxt; mid;
    check("wrap_pc2", {20'b0, ins_pc}, 32'h000);
    check("wrap_data2", ins_data, 32'h0);
    nxt; mid;
    check("wrap_pc3", {20'b0, ins_pc}, 32'h001);
    check("wrap_data3", ins_data, 32'h11);
    nxt;

    // Halt for 5 cycles: in-flight word still delivered, resume at fetch_pc
    redirect = 1'b1; redirect_pc = 12'h100;
    nxt;
    redirect = 1'b0;
    nxt;
    halt = 1'b1;
    mid;
    check("halt_h0_pc", {20'b0, ins_pc}, 32'h100);
    check("halt_h0_en", {31'b0, rom_en}, 32'd0);
    nxt; mid;
    check("halt_h1_valid", {31'b0, ins_valid}, 32'd1);
    check("halt_h1_pc", {20'b0, ins_pc}, 32'h101);
    nxt; mid;
    check("halt_h2_valid", {31'b0, ins_valid}, 32'd0);
    check("halt_h2_count", {29'b0, count}, 32'd0);
    nxt; nxt; mid;
    check("halt_h4_en", {31'b0, rom_en}, 32'd0);
    nxt;
    halt = 1'b0;
    mid;
    check("halt_rel_en", {31'b0, rom_en}, 32'd1);
    check("halt_rel_addr", {20'b0, rom_addr}, 32'h102);
    nxt; mid;
    check("halt_rel_n1_valid", {31'b0, ins_valid}, 32'd0);
    nxt; mid;
    check("halt_rel_n2_pc", {20'b0, ins_pc}, 32'h102);
    nxt;

    // Redirect while halted: nothing issued until halt drops, then 0x040 first
    halt = 1'b1;
    nxt; nxt; nxt;
    redirect = 1'b1; redirect_pc = 12'h040;
    mid;
    check("hredir_en", {31'b0, rom_en}, 32'd0);
    check("hredir_valid", {31'b0, ins_valid}, 32'd0);
    nxt;
    redirect = 1'b0;
    mid;
    check("hredir_n1_en", {31'b0, rom_en}, 32'd0);
    check("hredir_n1_count", {29'b0, count}, 32'd0);
    check("hredir_n1_addr", {20'b0, rom_addr}, 32'h040);
    nxt;
    halt = 1'b0;
    mid;
    check("hredir_rel_en", {31'b0, rom_en}, 32'd1);
    check("hredir_rel_addr", {20'b0, rom_addr}, 32'h040);
    nxt; mid;
    check("hredir_rel_n1_valid", {31'b0, ins_valid}, 32'd0);
    nxt; mid;
    check("hredir_rel_n2_valid", {31'b0, ins_valid}, 32'd1);
    check("hredir_rel_n2_pc", {20'b0, ins_pc}, 32'h040);
    check("hredir_rel_n2_data", ins_data, 32'h440);
    nxt;

    // Reset mid-stream with count 2
    ins_ready = 1'b0; redirect = 1'b1; redirect_pc = 12'h300;
    nxt;
    redirect = 1'b0;
    nxt; nxt;
    mid;
    check("mrst_pre_count", {29'b0, count}, 32'd2);
    rst = 1'b0;
    #1;
    check("mrst_en", {31'b0, rom_en}, 32'd0);
    check("mrst_valid", {31'b0, ins_valid}, 32'd0);
    check("mrst_count", {29'b0, count}, 32'd0);
    check("mrst_pc", {20'b0, ins_pc}, 32'd0);
    check("mrst_data", ins_data, 32'd0);
    check("mrst_addr", {20'b0, rom_addr}, 32'd0);
    nxt;
    ins_ready = 1'b1;
    nxt;
    rst = 1'b1;
    mid;
    check("mrst_rel_en", {31'b0, rom_en}, 32'd1);
    check("mrst_rel_addr", {20'b0, rom_addr}, 32'd0);
    nxt; nxt; mid;
    check("mrst_rel_valid", {31'b0, ins_valid}, 32'd1);
    check("mrst_rel_pc", {20'b0, ins_pc}, 32'd0);
    check("mrst_rel_data", ins_data, 32'd0);
    nxt; mid;
    check("mrst_rel_pc1", {20'b0, ins_pc}, 32'd1);
    nxt;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ins_prefetch_queue.md
Name: ins_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the CPU's instruction register.
- Drives a synchronous instruction ROM with 1-cycle read latency and buffers returned words in a DEPTH-entry FIFO.
- Presents words to the core with a valid/ready handshake, one per cycle in steady state.
- Redirect (taken branch) flushes buffered and in-flight words and restarts fetch at the new PC; halt freezes issue.

Parameters:
- WIDTH, 32: instruction word width.
- ADDRSIZE, 12: instruction address width.
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- PTRW, 2: log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rom_en  out  1  ROM read strobe.
- rom_addr  out  ADDRSIZE  ROM read address.
- rom_data  in  WIDTH  ROM word; valid the cycle after rom_en.
- ins_valid  out  1  head entry available.
- ins_data  out  WIDTH  head instruction word.
- ins_pc  out  ADDRSIZE  address of the head word.
- ins_ready  in  1  core accepts the head this cycle.
- redirect  in  1  flush and restart at redirect_pc.
- redirect_pc  in  ADDRSIZE  restart address.
- halt  in  1  suppress new ROM issues.
- count  out  PTRW+1  number of FIFO entries held.

Behaviour:
- State:
  - fetch_pc (ADDRSIZE).
  - FIFO storage: DEPTH × (WIDTH+ADDRSIZE).
  - wr_ptr, rd_ptr (PTRW).
  - count (PTRW+1).
  - inflight (1), inflight_pc (ADDRSIZE).
- Reset (rst low, asynchronous):
  - fetch_pc = 0, pointers = 0, count = 0, inflight = 0.
  - rom_en = 0, ins_valid = 0 forced combinationally.
  - rom_addr = 0, ins_data = 0, ins_pc = 0.
- Reset mid-operation discards the in-flight ROM word; the first issue after release is address 0.
- Issue, combinational: rom_en = rst & ~halt & (redirect | (count + inflight < DEPTH)).
  - rom_addr = redirect ? redirect_pc : fetch_pc.
  - The space test uses the pre-pop count (conservative), so the FIFO never overflows.
- On an issue edge: inflight <= 1, inflight_pc <= rom_addr, fetch_pc <= rom_addr + 1.
  - The increment wraps modulo 2^ADDRSIZE (4095 -> 0).
- With no issue: inflight <= 0.
- Response: in the cycle with inflight = 1 and no redirect, write {rom_data, inflight_pc} at wr_ptr, then wr_ptr++.
- Output: ins_valid = (count != 0) & ~redirect; ins_data and ins_pc come from the rd_ptr entry, combinationally.
- Pop: ins_valid & ins_ready advances rd_ptr.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Redirect takes priority over push, pop and halt:
  - wr_ptr = rd_ptr = 0, count = 0.
  - The in-flight response arriving this cycle is dropped.
  - If not halted, redirect_pc is issued the same cycle and fetch_pc <= redirect_pc + 1.
  - If halted, fetch_pc <= redirect_pc and inflight <= 0.
- Redirect latency: redirect asserted in cycle N gives ins_valid with ins_pc = redirect_pc in cycle N+2.
- Halt blocks only new issues:
  - An already in-flight word is still written.
  - The FIFO keeps draining to the core.
  - Deasserting halt resumes at fetch_pc.
- Cold start: reset released before edge 0 -> issue addr 0 at edge 0 -> ins_valid in cycle 2.
- Steady-state throughput is 1 word/cycle with ins_ready held 1.
- Invariants (assert in the bench):
  - count <= DEPTH.
  - count + inflight <= DEPTH.
  - ins_pc sequence is consecutive between redirects.

Test Plan:
- Cold start, ROM[a] = a·0x11, ins_ready = 1 -> ins_valid first high 2 cycles after release; ins_pc 0, 1, 2, … on consecutive cycles; data matches.
- ins_ready = 0 for 10 cycles -> count saturates at 4, rom_en drops, no entry is lost. Raise ins_ready -> pcs 0…3 are delivered, then fetch resumes at 4 with no gap or duplicate.
- Redirect to 0x200 while count = 3 and inflight = 1 -> ins_valid low that cycle, the stale in-flight word is never delivered, and the next delivered ins_pc = 0x200 two cycles later.
- fetch_pc reaches 0xFFE -> delivered pcs are 0xFFE, 0xFFF, 0x000, 0x001.
- Halt for 5 cycles with ready = 1 -> the in-flight word is delivered, then ins_valid falls. Halt with a redirect to 0x040 -> nothing issued; releasing halt fetches 0x040 first.
- Pull rst low mid-stream with count = 2 -> outputs go 0 immediately. After release, fetch restarts at 0 and no pre-reset word appears.
